// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issues one operation at a time to a combinational ALU. A request is
//   accepted over valid/ready. Its operands and opcode are registered onto
//   the ALU port. The result and flags are captured, and a tagged response
//   is returned over valid/ready. The block also keeps the flags of the last
//   legal operation and a count of completed legal operations.
//
//   Optional build macro: ALU_OVF_CALC_EN
//     When defined, the overflow flag is derived locally from the registered
//     operands and the ALU result sign, and alu_of is ignored.
//     When undefined, alu_of is captured unchanged.
//
//   Ports
//     clk, rst                  clock, synchronous active-high reset
//     req_valid/ready           request handshake
//     req_a, req_b, req_op      operands and opcode
//                               (000 add, 001 sub, 010 and, 011 or, 100 xor;
//                                101-111 illegal)
//     req_tag                   tag echoed on rsp_tag
//     alu_a, alu_b, alu_op      registered drive into the ALU
//     alu_y, alu_cf, alu_of,
//     alu_zero, alu_sf          ALU result and flags
//     rsp_valid/ready           response handshake
//     rsp_y, rsp_flags          result and flags {sf, zero, cf, of}
//     rsp_tag, rsp_err          echoed tag; illegal-opcode marker
//     flags_q                   flags of the last legal response
//     ops_done                  count of legal responses (wraps)
//
//   state | meaning
//   IDLE  | ready for a request
//   EXEC  | ALU inputs stable; result captured at end of cycle
//   RESP  | response presented until rsp_ready
module alu_issue_ctrl #(
  parameter int N    = 32,
  parameter int TAGW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [N-1:0]    req_a,
  input  logic [N-1:0]    req_b,
  input  logic [2:0]      req_op,
  input  logic [TAGW-1:0] req_tag,
  output logic [N-1:0]    alu_a,
  output logic [N-1:0]    alu_b,
  output logic [2:0]      alu_op,
  input  logic [N-1:0]    alu_y,
  input  logic            alu_cf,
  input  logic            alu_of,
  input  logic            alu_zero,
  input  logic            alu_sf,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [N-1:0]    rsp_y,
  output logic [3:0]      rsp_flags,
  output logic [TAGW-1:0] rsp_tag,
  output logic            rsp_err,
  output logic [3:0]      flags_q,
  output logic [15:0]     ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   legal;
  logic   rsp_hs;
  logic   of_bit;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    legal     = (req_op <= 3'd4);
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          accept    = 1'b1;
          state_nxt = legal ? EXEC : RESP;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rsp_hs = rsp_valid & rsp_ready;

`ifdef ALU_OVF_CALC_EN
  // alu_a/alu_b only change on a legal accept, so they are the latched operands.
  logic alu_of_unused;
  assign alu_of_unused = alu_of;

  always_comb begin
    of_bit = 1'b0;
    case (alu_op)
      3'b000:  of_bit = (alu_a[N-1] == alu_b[N-1]) && (alu_y[N-1] != alu_a[N-1]);
      3'b001:  of_bit = (alu_a[N-1] != alu_b[N-1]) && (alu_y[N-1] != alu_a[N-1]);
      default: of_bit = 1'b0;
    endcase
  end
`else
  assign of_bit = alu_of;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_y     <= '0;
      rsp_flags <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
      flags_q   <= '0;
      ops_done  <= '0;
    end else begin
      if (accept) begin
        rsp_tag <= req_tag;
        if (legal) begin
          alu_a   <= req_a;
          alu_b   <= req_b;
          alu_op  <= req_op;
          rsp_err <= 1'b0;
        end else begin
          // Illegal op skips the ALU entirely; alu_* keep their old values.
          rsp_err   <= 1'b1;
          rsp_y     <= '0;
          rsp_flags <= '0;
        end
      end
      if (state == EXEC) begin
        rsp_y     <= alu_y;
        rsp_flags <= {alu_sf, alu_zero, alu_cf, of_bit};
      end
      if (rsp_hs && !rsp_err) begin
        flags_q  <= rsp_flags;
        ops_done <= ops_done + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Testbench for alu_issue_ctrl. It uses a behavioural ALU, directed
// requests, and a scoreboard queue that is drained by an independent
// response monitor.
module tb_alu_issue_ctrl;
  localparam int N    = 32;
  localparam int TAGW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_valid, req_ready;
  logic [N-1:0]    req_a, req_b;
  logic [2:0]      req_op;
  logic [TAGW-1:0] req_tag;
  logic [N-1:0]    alu_a, alu_b, alu_y;
  logic [2:0]      alu_op;
  logic            alu_cf, alu_of, alu_zero, alu_sf;
  logic            rsp_valid, rsp_ready;
  logic [N-1:0]    rsp_y;
  logic [3:0]      rsp_flags, flags_q;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;
  logic [15:0]     ops_done;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.N(N), .TAGW(TAGW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_y(alu_y), .alu_cf(alu_cf), .alu_of(alu_of),
    .alu_zero(alu_zero), .alu_sf(alu_sf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_y(rsp_y), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .flags_q(flags_q), .ops_done(ops_done)
  );

  // Behavioural ALU driven by the DUT's alu_* outputs.
  logic [N:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    alu_y   = '0;
    alu_cf  = 1'b0;
    alu_of  = 1'b0;
    case (alu_op)
      3'b000: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b};
        alu_y   = alu_sum[N-1:0];
        alu_cf  = alu_sum[N];
        alu_of  = (alu_a[N-1] == alu_b[N-1]) && (alu_y[N-1] != alu_a[N-1]);
      end
      3'b001: begin
        alu_y  = alu_a - alu_b;
        alu_cf = (alu_a < alu_b);
        alu_of = (alu_a[N-1] != alu_b[N-1]) && (alu_y[N-1] != alu_a[N-1]);
      end
      3'b010:  alu_y = alu_a & alu_b;
      3'b011:  alu_y = alu_a | alu_b;
      3'b100:  alu_y = alu_a ^ alu_b;
      default: alu_y = '0;
    endcase
    alu_zero = (alu_y == '0);
    alu_sf   = alu_y[N-1];
  end

  typedef struct {
    logic [N-1:0]    y;
    logic [3:0]      flags;
    logic [TAGW-1:0] tag;
    logic            err;
    int              due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   exp_ops = 0;
  logic [3:0] exp_fq = 4'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every response handshake is checked against the queue head.
  always @(posedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rsp: got tag %0h expected no response", rsp_tag);
      end else begin
        mon_e = sb.pop_front();
        chk("rsp_y",     rsp_y,     mon_e.y);
        chk("rsp_flags", rsp_flags, mon_e.flags);
        chk("rsp_tag",   rsp_tag,   mon_e.tag);
        chk("rsp_err",   rsp_err,   mon_e.err);
        if (mon_e.due != 0) chk("rsp_latency", cyc, mon_e.due);
      end
    end
  end

  // Called at a negedge. Returns at the negedge after the accept edge.
  task automatic send(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                      input logic [TAGW-1:0] tag, input logic [N-1:0] y, input logic [3:0] fl,
                      input bit push, input bit lat_chk, output int acc);
    int waited;
    bit err;
    waited    = 0;
    err       = (op > 3'd4);
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got req_ready 0 expected 1");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (push)
      sb.push_back('{y: err ? '0 : y, flags: err ? 4'h0 : fl, tag: tag, err: err,
                     due: lat_chk ? acc + (err ? 1 : 2) : 0});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic legal(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [TAGW-1:0] tag, input logic [N-1:0] y, input logic [3:0] fl);
    int acc;
    send(op, a, b, tag, y, fl, 1'b1, 1'b1, acc);
    exp_ops++;
    exp_fq = fl;
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, h, waited;
    req_valid = 1'b0;
    req_a     = '0;
    req_b     = '0;
    req_op    = '0;
    req_tag   = '0;
    rsp_ready = 1'b1;
    rst       = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    chk("reset_req_ready", req_ready, 1);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_alu_op",    alu_op,    0);
    chk("reset_alu_a",     alu_a,     0);
    chk("reset_rsp_y",     rsp_y,     0);
    chk("reset_flags_q",   flags_q,   0);
    chk("reset_ops_done",  ops_done,  0);

    legal(3'b000, 32'd7, 32'd5, 4'd3, 32'd12, 4'b0000);
    drain();
    chk("ops_done_first", ops_done, 1);
    chk("flags_q_first",  flags_q,  0);

    legal(3'b001, 32'd5, 32'd5, 4'd1, 32'd0, 4'b0100);
    legal(3'b001, 32'd0, 32'd1, 4'd2, 32'hFFFF_FFFF, 4'b1010);
    legal(3'b000, 32'h7FFF_FFFF, 32'd1, 4'd4, 32'h8000_0000, 4'b1001);
    legal(3'b000, 32'hFFFF_FFFF, 32'd1, 4'd5, 32'd0, 4'b0110);
    legal(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd6, 32'hF000_F000, 4'b1000);
    legal(3'b011, 32'h1234_0000, 32'h0000_5678, 4'd7, 32'h1234_5678, 4'b0000);
    legal(3'b100, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 4'd8, 32'd0, 4'b0100);
    drain();
    chk("ops_done_mix", ops_done, exp_ops);
    chk("flags_q_mix",  flags_q,  exp_fq);

    send(3'b101, 32'd1, 32'd2, 4'd9, 32'd0, 4'h0, 1'b1, 1'b1, acc);
    drain();
    chk("illegal_alu_op",   alu_op,   3'b100);
    chk("illegal_alu_a",    alu_a,    32'hA5A5_A5A5);
    chk("illegal_flags_q",  flags_q,  exp_fq);
    chk("illegal_ops_done", ops_done, exp_ops);

    legal(3'b000, 32'd1, 32'd1, 4'd10, 32'd2, 4'b0000);
    drain();

    // Hold the response for four cycles; then accept must follow the handshake.
    rsp_ready = 1'b0;
    send(3'b010, 32'd3, 32'd5, 4'd11, 32'd1, 4'b0000, 1'b1, 1'b0, acc);
    exp_ops++;
    exp_fq = 4'b0000;
    waited = 0;
    while (!rsp_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < 4; i++) begin
      chk("stall_rsp_valid", rsp_valid, 1);
      chk("stall_rsp_y",     rsp_y,     1);
      chk("stall_rsp_tag",   rsp_tag,   4'd11);
      chk("stall_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    h = cyc;
    send(3'b000, 32'd10, 32'd20, 4'd12, 32'd30, 4'b0000, 1'b1, 1'b1, acc);
    exp_ops++;
    chk("accept_after_hs", acc, h + 1);
    legal(3'b001, 32'd0, 32'd1, 4'd13, 32'hFFFF_FFFF, 4'b1010);
    drain();
    chk("ops_done_pre_rst", ops_done, exp_ops);
    chk("flags_q_pre_rst",  flags_q,  exp_fq);

    // Reset while the op is in EXEC: it must be dropped silently.
    send(3'b000, 32'd4, 32'd4, 4'd14, 32'd8, 4'b0000, 1'b0, 1'b0, acc);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_flags_q",   flags_q,   0);
    chk("rst_ops_done",  ops_done,  0);
    repeat (10) @(negedge clk);
    chk("rst_no_rsp_valid", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
